// File: rtl/c64_bus_arbiter_if.sv
// Shared memory-bus bundle between cpu6510, VIC-II DMA and the RAM/IO decode.
// The arbiter uses the master modport; CPU/VIC/memory side models use slave.
interface c64_bus_arbiter_if;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic        cpu_rdy;
    logic [15:0] vic_ab;
    logic        vic_dma_req;
    logic [15:0] mem_ab;
    logic [7:0]  mem_do;
    logic        mem_we;
    logic        phase;
    logic        ba;
    logic        aec;
    // Arbiter state for observation: 0 = IDLE, 1 = BA_WAIT, 2 = STEAL
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_cnt;

    modport master (
        input  cpu_ab, cpu_do, cpu_we, vic_ab, vic_dma_req,
        output cpu_rdy, mem_ab, mem_do, mem_we, phase, ba, aec, dbg_state, dbg_cnt
    );

    modport slave (
        output cpu_ab, cpu_do, cpu_we, vic_ab, vic_dma_req,
        input  cpu_rdy, mem_ab, mem_do, mem_we, phase, ba, aec, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/c64_bus_arbiter.sv
// phi1/phi2 bus arbiter between cpu6510 and VIC-II DMA, with BA lead before AEC steal.
// Optional macro CPU_WRITE_THROUGH_BA_EN lets CPU writes complete during the BA lead.
module c64_bus_arbiter #(
    parameter int unsigned BA_LEAD = 3  // legal range 1..7
) (
    input  logic                   clk,
    input  logic                   reset,
    c64_bus_arbiter_if.master      bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BA_WAIT = 2'd1,
        STEAL   = 2'd2
    } state_t;

    localparam logic [2:0] LEAD_LAST = 3'(BA_LEAD - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       phase;
    logic       wr_grant;
    logic       aec;

    // State only moves on the edge that closes phi2, i.e. the C64 cycle boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= 1'b0;
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            phase <= ~phase;
            if (phase) begin
                case (state)
                    IDLE: begin
                        if (bus.vic_dma_req) begin
                            state <= BA_WAIT;
                            cnt   <= 3'd0;
                        end
                    end
                    BA_WAIT: begin
                        if (!bus.vic_dma_req) begin
                            state <= IDLE;
                            cnt   <= 3'd0;
                        end else if (cnt == LEAD_LAST) begin
                            state <= STEAL;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    STEAL: begin
                        if (!bus.vic_dma_req) begin
                            state <= IDLE;
                            cnt   <= 3'd0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end
                endcase
            end
        end
    end

`ifdef CPU_WRITE_THROUGH_BA_EN
    // The 6510 ignores RDY on write cycles, so writes still own phi2 during the lead.
    assign wr_grant = bus.cpu_we;
`else
    assign wr_grant = 1'b0;
`endif

    // phase gates everything, so the CPU can advance at most once per C64 cycle.
    assign aec = phase && ((state == IDLE) || ((state == BA_WAIT) && wr_grant));

    assign bus.phase     = phase;
    assign bus.ba        = (state == IDLE);
    assign bus.aec       = aec;
    assign bus.cpu_rdy   = aec;
    assign bus.mem_ab    = aec ? bus.cpu_ab : bus.vic_ab;
    assign bus.mem_do    = bus.cpu_do;
    assign bus.mem_we    = aec && bus.cpu_we;
    assign bus.dbg_state = state;
    assign bus.dbg_cnt   = cnt;
endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Self-checking bench for c64_bus_arbiter: cycle-level model feeding an expected
// queue, plus directed checks on reset, lead length, steal length and write-through.
module tb_c64_bus_arbiter;
  localparam int unsigned BA_LEAD = 3;
`ifdef CPU_WRITE_THROUGH_BA_EN
  localparam logic WT_EN = 1'b1;
`else
  localparam logic WT_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  c64_bus_arbiter_if bus();

  c64_bus_arbiter #(.BA_LEAD(BA_LEAD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // output word: {phase, ba, aec, cpu_rdy, mem_we, mem_ab, mem_do}
  logic [28:0] exp_q[$];
  logic [1:0]  st_q[$];

  // reference model: 0 idle, 1 ba lead, 2 steal; m_left = lead cycles remaining
  int   m_state = 0;
  int   m_left = 0;
  logic m_phase = 1'b0;

  // observation counters over phi2 slots
  int   rdy_low_cnt = 0;
  int   steal_cnt = 0;
  int   ba_low_cnt = 0;
  logic last_phi2_we = 1'b0;
  logic last_phi2_rdy = 1'b0;
  logic [15:0] vab_v = 16'h0400;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_left = 0;
    m_phase = 1'b0;
  endtask

  task automatic model_edge();
    if (m_phase) begin
      case (m_state)
        0: if (bus.vic_dma_req) begin m_state = 1; m_left = BA_LEAD; end
        1: begin
          if (!bus.vic_dma_req) m_state = 0;
          else begin
            m_left--;
            if (m_left == 0) m_state = 2;
          end
        end
        default: if (!bus.vic_dma_req) m_state = 0;
      endcase
    end
    m_phase = ~m_phase;
  endtask

  function automatic logic [28:0] model_out();
    logic a;
    logic g;
    g = WT_EN & bus.cpu_we;
    a = m_phase && ((m_state == 0) || ((m_state == 1) && g));
    return {m_phase, (m_state == 0), a, a, a && bus.cpu_we,
            a ? bus.cpu_ab : bus.vic_ab, bus.cpu_do};
  endfunction

  // one clk period: model follows the edge, new inputs are driven, outputs checked at negedge
  task automatic step(input logic req, input logic we, input logic [15:0] cab,
                      input logic [7:0] cdo, input logic [15:0] vab);
    logic [28:0] obs;
    @(posedge clk);
    model_edge();
    #1;
    bus.vic_dma_req = req;
    bus.cpu_we = we;
    bus.cpu_ab = cab;
    bus.cpu_do = cdo;
    bus.vic_ab = vab;
    exp_q.push_back(model_out());
    st_q.push_back(2'(m_state));
    @(negedge clk);
    obs = {bus.phase, bus.ba, bus.aec, bus.cpu_rdy, bus.mem_we, bus.mem_ab, bus.mem_do};
    check("outs", 32'(obs), 32'(exp_q.pop_front()));
    check("state", 32'(bus.dbg_state), 32'(st_q.pop_front()));
    if (bus.phase) begin
      if (!bus.cpu_rdy) rdy_low_cnt++;
      if (bus.dbg_state == 2'd2) steal_cnt++;
      if (!bus.ba) ba_low_cnt++;
      last_phi2_we = bus.mem_we;
      last_phi2_rdy = bus.cpu_rdy;
    end
  endtask

  task automatic cycle(input logic req, input logic we, input logic [15:0] cab, input logic [7:0] cdo);
    step(req, we, cab, cdo, vab_v);
    step(req, we, cab, cdo, vab_v);
  endtask

  task automatic clear_counts();
    rdy_low_cnt = 0;
    steal_cnt = 0;
    ba_low_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rq;
    bus.vic_dma_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_ab = 16'hC000;
    bus.cpu_do = 8'h00;
    bus.vic_ab = 16'h0400;
    model_reset();

    // reset values
    #12;
    check("rst0_phase", 32'(bus.phase), 32'd0);
    check("rst0_ba", 32'(bus.ba), 32'd1);
    check("rst0_aec", 32'(bus.aec), 32'd0);
    check("rst0_rdy", 32'(bus.cpu_rdy), 32'd0);
    check("rst0_we", 32'(bus.mem_we), 32'd0);
    check("rst0_ab", 32'(bus.mem_ab), 32'h0400);
    @(negedge clk);
    #2 reset = 1'b1;

    // idle: CPU owns every phi2
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'hC000, 8'h00);

    // long DMA: lead then steal, release resumes CPU one boundary after the drop
    clear_counts();
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 16'hC000, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'hC000, 8'h00);
    check("hold_rdy_low", 32'(rdy_low_cnt), 32'd40);
    check("hold_steal", 32'(steal_cnt), 32'(40 - BA_LEAD));

    // CPU write during the BA lead, then during steal
    cycle(1'b1, 1'b0, 16'hC000, 8'h00);
    cycle(1'b1, 1'b1, 16'hD020, 8'h05);
    check("wr_lead_we", 32'(last_phi2_we), 32'(WT_EN));
    check("wr_lead_rdy", 32'(last_phi2_rdy), 32'(WT_EN));
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'hD020, 8'h05);
    check("wr_steal_we", 32'(last_phi2_we), 32'd0);

    // drop for one cycle out of steal, re-assert: full lead again
    cycle(1'b0, 1'b0, 16'hC000, 8'h00);
    cycle(1'b1, 1'b0, 16'hC000, 8'h00);
    clear_counts();
    for (int i = 0; i < BA_LEAD; i++) cycle(1'b1, 1'b0, 16'hC000, 8'h00);
    check("reassert_lead", 32'(steal_cnt), 32'd0);
    cycle(1'b1, 1'b0, 16'hC000, 8'h00);
    check("reassert_steal", 32'(steal_cnt), 32'd1);

    // one-cycle pulse: single lead cycle, no steal
    cycle(1'b0, 1'b0, 16'hC000, 8'h00);
    cycle(1'b0, 1'b0, 16'hC000, 8'h00);
    clear_counts();
    cycle(1'b1, 1'b0, 16'hC000, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'hC000, 8'h00);
    check("pulse_no_steal", 32'(steal_cnt), 32'd0);
    check("pulse_ba_low", 32'(ba_low_cnt), 32'd1);

    // random traffic
    rq = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 6) == 0) rq = ~rq;
      vab_v = 16'($urandom_range(0, 16'hFFFF));
      cycle(rq, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)),
            8'($urandom_range(0, 255)));
    end

    // reset in the middle of a steal, asserted between edges during phi2
    vab_v = 16'h0400;
    for (int i = 0; i < BA_LEAD + 2; i++) cycle(1'b1, 1'b1, 16'hC000, 8'h11);
    check("pre_rst_steal", 32'(bus.dbg_state), 32'd2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_phase", 32'(bus.phase), 32'd0);
    check("rst_ba", 32'(bus.ba), 32'd1);
    check("rst_aec", 32'(bus.aec), 32'd0);
    check("rst_rdy", 32'(bus.cpu_rdy), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_ab", 32'(bus.mem_ab), 32'h0400);
    bus.vic_dma_req = 1'b0;
    bus.cpu_we = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("rel_phase", 32'(bus.phase), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'hC000, 8'h00);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 16'hC000, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'hC000, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/c64_bus_arbiter.md
Name: c64_bus_arbiter

Overview:
Time-multiplexes the single system memory bus between the cpu6510 core and the VIC-II DMA engine, in the C64 phi1/phi2 style.
- Each C64 cycle spans two clk periods: the phi1 slot always belongs to the VIC; the phi2 slot belongs to the CPU unless the VIC has stolen it.
- Generates the CPU RDY qualifier plus BA/AEC, including the BA lead period in which CPU writes may still complete.
- Sits between cpu6510, the VIC-II and the RAM/IO decode.

Parameters:
BA_LEAD, 3, number of phi2 slots between BA falling and AEC being held low (VIC steals phi2); legal values 1..7.

Ports:
clk  in  1  system clock (two clk per C64 cycle)
reset  in  1  asynchronous, active-low reset
cpu_ab  in  16  CPU address
cpu_do  in  8  CPU write data
cpu_we  in  1  CPU write request
cpu_rdy  out  1  CPU advance enable, fed to cpu6510 RDY
vic_ab  in  16  VIC DMA address
vic_dma_req  in  1  VIC requests phi2 slots (badline/sprite DMA)
mem_ab  out  16  muxed memory address
mem_do  out  8  muxed write data
mem_we  out  1  memory write strobe
phase  out  1  0 = phi1 (VIC slot), 1 = phi2 (CPU slot)
ba  out  1  bus available, active-high
aec  out  1  1 = CPU drives bus this slot

Behaviour:
Phase register
- Toggles every clk; reset value 0.

State machine
- States: IDLE, BA_WAIT, STEAL; 3-bit lead counter cnt.
- Reset: state=IDLE, cnt=0, phase=0.
- Transitions are evaluated only on the clk edge where phase==1, i.e. at the end of phi2 / C64 cycle boundary.
- IDLE: if vic_dma_req=1, go to BA_WAIT with cnt=0.
- BA_WAIT:
  - If vic_dma_req=0, go to IDLE.
  - Else if cnt==BA_LEAD-1, go to STEAL.
  - Else cnt<=cnt+1.
- STEAL: if vic_dma_req=0, go to IDLE and clear cnt.
- vic_dma_req is ignored on phase==0 edges.

Outputs (combinational from registered state, phase and inputs)
- ba = (state==IDLE).
- aec = phase && (state==IDLE || (state==BA_WAIT && wr_grant)).
- wr_grant = cpu_we, gated by the optional feature.
- cpu_rdy = aec.
  - This guarantees the CPU advances at most once per C64 cycle.
  - cpu_rdy is always 0 in the phi1 slot.
- mem_ab = aec ? cpu_ab : vic_ab.
- mem_do = cpu_do.
- mem_we = aec && cpu_we.
- Reset values: phase=0, ba=1, aec=0, cpu_rdy=0, mem_we=0, mem_ab=vic_ab.

Reads during BA_WAIT and STEAL
- CPU reads stall: cpu_rdy=0, and the CPU holds its address.

Boundary conditions
- vic_dma_req dropping in BA_WAIT before the lead expires: return to IDLE with no steal; ba rises at the next cycle boundary.
- vic_dma_req re-asserting in the same cycle STEAL exits: the next boundary enters BA_WAIT with cnt=0. The full lead is always re-imposed.
- Reset asserted mid-steal: outputs go to reset values immediately (asynchronous). On release, the first clk edge is a phi1 slot.
- BA_LEAD=1: one BA_WAIT phi2 slot, then STEAL.

Optional Feature:
Macro: CPU_WRITE_THROUGH_BA_EN
- Defined: wr_grant = cpu_we. In BA_WAIT, CPU writes in phi2 slots are granted (aec=1, cpu_rdy=1, mem_we=1), modelling 6510 RDY-ignored-on-write.
- Undefined: wr_grant = 0. BA_WAIT stalls every CPU access, so the CPU never drives the bus when ba=0.

Test Plan:
- Reset release, vic_dma_req=0, cpu_ab=16'hC000, vic_ab=16'h0400 -> phase alternates 0,1; mem_ab=0400 in phi1, C000 in phi2; cpu_rdy pulses 1 on phi2 only; ba=1 throughout.
- vic_dma_req=1 sampled at a cycle boundary, CPU reading, BA_LEAD=3 -> ba=0 next cycle; cpu_rdy=0 for 3 BA_WAIT cycles, then STEAL; mem_ab=vic_ab in both slots.
- With CPU_WRITE_THROUGH_BA_EN: cpu_we=1, cpu_ab=16'hD020, cpu_do=8'h05 during BA_WAIT -> phi2 mem_we=1, mem_ab=D020, mem_do=05, cpu_rdy=1. Same stimulus without the macro -> mem_we=0, cpu_rdy=0.
- vic_dma_req held 40 cycles then dropped -> STEAL for 37 cycles; ba=1 and cpu_rdy resumes in phi2 of the cycle after the boundary where the drop was sampled.
- vic_dma_req pulsed 1 for one cycle only -> one BA_WAIT cycle, back to IDLE, no STEAL entered.
- reset asserted during STEAL, between edges -> ba=1, aec=0, cpu_rdy=0, mem_we=0 immediately; after release, phase=0 on the first edge.
